dp_chunk_accumulator: RTL and testbench
=======================================

DP_CHUNK_ACCUMULATOR -- requirements
Module: dp_chunk_accumulator

Interface
REQ-001 SHALL have parameter DEPTH, default 4: lanes per chunk, matching the parallel dot-product width.
REQ-002 SHALL have parameter ACC_W, default 32: accumulator and result width, legal range 18..48.
REQ-003 SHALL have parameter CNT_W, default 8: chunk-count width.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1: begin an operation; sampled only in IDLE.
REQ-007 SHALL have port num_chunks  input  CNT_W: chunk count, captured on an accepted start.
REQ-008 SHALL have ports in_valid input 1 / in_ready output 1: operand-chunk handshake.
REQ-009 SHALL have ports in_a, in_b  input  8 x DEPTH (unpacked): unsigned operand chunk.
REQ-010 SHALL have ports dp_a, dp_b  output  8 x DEPTH (unpacked): registered operands to the dot-product unit.
REQ-011 SHALL have port dp_res  input  17: combinational dot-product result for dp_a/dp_b; unsigned, zero-extended.
REQ-012 SHALL have ports out_valid output 1 / out_ready input 1: result handshake.
REQ-013 SHALL have port out_data  output  ACC_W: final accumulated sum.
REQ-014 SHALL have port out_ovf  output  1: sticky overflow flag for the current operation.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE.
- IDLE->RUN on start with num_chunks!=0.
- IDLE->DONE on start with num_chunks==0.
- RUN->DONE once the last chunk is accumulated.
- DONE->IDLE on out_valid&&out_ready.
REQ-016 SHALL, on an accepted start, clear the accumulator, out_ovf and both chunk counters.
REQ-017 SHALL drive in_ready=1 only in RUN while accepted-chunk count < num_chunks; in_ready SHALL be 0 in IDLE and DONE.
REQ-018 SHALL register in_a/in_b into dp_a/dp_b on a handshake (cycle N) and set an internal dp_vld for cycle N+1.
- dp_a/dp_b SHALL hold their value when no handshake occurs.
REQ-019 SHALL add zero-extended dp_res to the accumulator at the end of every cycle with dp_vld=1.
- Back-to-back handshakes SHALL sustain one chunk per cycle.
REQ-020 SHALL assert out_valid in the cycle after the last accumulation (latency: last handshake N -> out_valid at N+2).
REQ-021 SHALL hold out_valid, out_data and out_ovf stable until out_ready; out_valid&&out_ready in the same cycle SHALL complete the transfer.
REQ-022 SHALL ignore start outside IDLE, including a start that coincides with the DONE->IDLE transfer cycle.
REQ-023 SHALL, for num_chunks==0, produce out_data=0 and out_ovf=0 one cycle after start.
REQ-024 SHALL set out_ovf when an addition carries beyond ACC_W bits; without the macro in REQ-028 the sum SHALL wrap modulo 2^ACC_W.

Reset
REQ-025 SHALL, on rst asserted at any time including mid-operation, immediately force state=IDLE, in_ready=0, out_valid=0, out_data=0, out_ovf=0, dp_a=dp_b=0, dp_vld=0, counters=0.
REQ-026 SHALL discard any partially accumulated operation on reset, with no output produced.
REQ-027 SHALL resume normal behaviour on the first rising clk after rst deasserts.

Configuration
REQ-028 SHALL, with DP_ACC_SAT_EN defined, saturate the accumulator at 2^ACC_W-1 on overflow (out_ovf still set).
REQ-029 SHALL, with DP_ACC_SAT_EN undefined, wrap as in REQ-024; the port list SHALL be identical in both builds.

Structure
REQ-030 SHALL place the state enum (IDLE/RUN/DONE), the operand width 8 and the dp_res width 17 in shared package dp_pkg.
REQ-031 SHALL instantiate no sub-module; dot_product_parallel SHALL remain external and connect through dp_a/dp_b/dp_res.

Verification
REQ-032 SHALL verify: num_chunks=3, every lane a=10 b=10, back-to-back input, bench dot-product model -> out_data=1200, out_ovf=0, out_valid exactly 2 cycles after the 3rd handshake.
REQ-033 SHALL verify: num_chunks=0 -> out_valid one cycle after start, out_data=0, in_ready never asserted.
REQ-034 SHALL verify: ACC_W=18 in the macro-off build, 11 chunks with all operands 255 and a bench model returning 17-bit results -> out_data equals the bench wrap result and out_ovf=1; the same stimulus in the macro-on build -> out_data=262143 and out_ovf=1.
REQ-035 SHALL verify: out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0, a start pulse is ignored, completion occurs on the out_ready rise.
REQ-036 SHALL verify: rst pulsed after 2 of 4 chunks -> all outputs 0 immediately; a new 1-chunk operation (a=b=1) -> out_data=4.
REQ-037 SHALL verify: in_valid toggled every other cycle for 4 chunks (a=1, b=3) -> out_data=48, and no chunk is accepted beyond num_chunks.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared types and widths for the chunked dot-product accumulator and its
// external dot-product unit.
package dp_pkg;

  localparam int OPND_W   = 8;
  localparam int DP_RES_W = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dp_state_t;

endpackage

// File: rtl/dp_chunk_accumulator.sv
// Streams operand chunks into an external dot-product unit and sums its results.
// Build option: define DP_ACC_SAT_EN to saturate the accumulator instead of wrapping.
module dp_chunk_accumulator
  import dp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_chunks,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPND_W-1:0]   in_a [DEPTH],
  input  logic [OPND_W-1:0]   in_b [DEPTH],
  output logic [OPND_W-1:0]   dp_a [DEPTH],
  output logic [OPND_W-1:0]   dp_b [DEPTH],
  input  logic [DP_RES_W-1:0] dp_res,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_data,
  output logic                out_ovf,
  output dp_state_t           dbg_state
);

  // Both handshakes transfer on a rising edge where valid && ready; a source
  // holds its payload while valid is high and ready is low, and ready never
  // depends combinationally on valid.

  dp_state_t          state;
  logic [CNT_W-1:0]   num_r;
  logic [CNT_W-1:0]   in_cnt;
  logic [CNT_W-1:0]   acc_cnt;
  logic               dp_vld;
  logic [ACC_W-1:0]   acc;
  logic               ovf;

  logic               in_fire;
  logic [CNT_W:0]     in_cnt_nxt;
  logic [CNT_W:0]     acc_cnt_nxt;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   acc_nxt;

  assign in_fire     = in_valid && in_ready;
  assign in_cnt_nxt  = {1'b0, in_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign acc_cnt_nxt = {1'b0, acc_cnt} + {{CNT_W{1'b0}}, 1'b1};

  // One spare bit above the accumulator catches the carry used for out_ovf.
  assign sum = {1'b0, acc} + {{(ACC_W + 1 - DP_RES_W){1'b0}}, dp_res};

`ifdef DP_ACC_SAT_EN
  assign acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  assign out_data  = acc;
  assign out_ovf   = ovf;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      num_r     <= '0;
      in_cnt    <= '0;
      acc_cnt   <= '0;
      dp_vld    <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        dp_a[i] <= '0;
        dp_b[i] <= '0;
      end
    end else begin
      dp_vld <= in_fire;
      if (in_fire) begin
        dp_a <= in_a;
        dp_b <= in_b;
      end

      case (state)
        IDLE: begin
          if (start) begin
            num_r   <= num_chunks;
            in_cnt  <= '0;
            acc_cnt <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
            if (num_chunks == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state    <= RUN;
              in_ready <= 1'b1;
            end
          end
        end

        RUN: begin
          if (in_fire) begin
            in_cnt   <= in_cnt_nxt[CNT_W-1:0];
            in_ready <= (in_cnt_nxt < {1'b0, num_r});
          end
          // dp_res belongs to the chunk registered on the previous edge.
          if (dp_vld) begin
            acc     <= acc_nxt;
            ovf     <= ovf | sum[ACC_W];
            acc_cnt <= acc_cnt_nxt[CNT_W-1:0];
            if (acc_cnt_nxt == {1'b0, num_r}) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dp_chunk_accumulator.sv
// Directed bench for dp_chunk_accumulator with a behavioural dot-product unit;
// a second instance with ACC_W=18 covers overflow (wrap or DP_ACC_SAT_EN saturate).
module tb_dp_chunk_accumulator;
  import dp_pkg::*;

  localparam int DEPTH = 4;
  localparam int ACC_W = 32;
  localparam int CNT_W = 8;
  localparam int W_ACC = 18;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks;
  int n_fail;

  // main instance
  logic                start, in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [CNT_W-1:0]    num_chunks;
  logic [7:0]          in_a [DEPTH];
  logic [7:0]          in_b [DEPTH];
  logic [7:0]          dp_a [DEPTH];
  logic [7:0]          dp_b [DEPTH];
  logic [16:0]         dp_res;
  logic [ACC_W-1:0]    out_data;
  dp_state_t           dbg_state;

  // narrow instance for overflow
  logic                w_start, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_ovf;
  logic [CNT_W-1:0]    w_num_chunks;
  logic [7:0]          w_in_a [DEPTH];
  logic [7:0]          w_in_b [DEPTH];
  logic [7:0]          w_dp_a [DEPTH];
  logic [7:0]          w_dp_b [DEPTH];
  logic [16:0]         w_dp_res;
  logic [W_ACC-1:0]    w_out_data;
  dp_state_t           w_dbg_state;

  function automatic logic [16:0] dot_model(input logic [7:0] a [DEPTH], input logic [7:0] b [DEPTH]);
    longint s = 0;
    for (int i = 0; i < DEPTH; i++) s += longint'(a[i]) * longint'(b[i]);
    return 17'(s);
  endfunction

  always_comb dp_res   = dot_model(dp_a, dp_b);
  always_comb w_dp_res = dot_model(w_dp_a, w_dp_b);

  dp_chunk_accumulator #(.DEPTH(DEPTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_chunks(num_chunks),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dp_a(dp_a), .dp_b(dp_b), .dp_res(dp_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .dbg_state(dbg_state)
  );

  dp_chunk_accumulator #(.DEPTH(DEPTH), .ACC_W(W_ACC), .CNT_W(CNT_W)) dut18 (
    .clk(clk), .rst(rst), .start(w_start), .num_chunks(w_num_chunks),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a), .in_b(w_in_b),
    .dp_a(w_dp_a), .dp_b(w_dp_b), .dp_res(w_dp_res),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_ovf(w_out_ovf), .dbg_state(w_dbg_state)
  );

  // driver: start an operation and feed chunks until out_valid appears
  task automatic run_op(input int n, input logic [7:0] a, input logic [7:0] b, input bit gap,
                        output int hs, output int last_hs, output int start_cyc,
                        output int ov_cyc, output bit rdy_seen);
    hs = 0; last_hs = -1; ov_cyc = -1; rdy_seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    num_chunks = CNT_W'(n);
    start_cyc = cyc;
    for (int j = 0; j < DEPTH; j++) begin
      in_a[j] = a;
      in_b[j] = b;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) begin
        ov_cyc = cyc;
        break;
      end
      in_valid = gap ? (i % 2 == 0) : 1'b1;
      if (in_ready) rdy_seen = 1'b1;
      if (in_valid && in_ready) begin
        hs++;
        last_hs = cyc;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic complete_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 0; in_valid = 0; out_ready = 0; num_chunks = '0;
    w_start = 0; w_in_valid = 0; w_out_ready = 0; w_num_chunks = '0;
    for (int j = 0; j < DEPTH; j++) begin
      in_a[j] = 8'd0; in_b[j] = 8'd0; w_in_a[j] = 8'd0; w_in_b[j] = 8'd0;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
    end
    n_checks++;
    if (out_data !== '0 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_out: data=%0d ovf=%b want 0 0", out_data, out_ovf);
    end
    n_checks++;
    if (dbg_state !== IDLE || dp_a[0] !== 8'd0 || dp_b[DEPTH-1] !== 8'd0) begin
      n_fail++; $display("FAIL reset_state: state=%0d dp_a0=%0d dp_b3=%0d want 0 0 0", dbg_state, dp_a[0], dp_b[DEPTH-1]);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int hs, last_hs, sc, ov;
    bit rs;
    run_op(3, 8'd10, 8'd10, 1'b0, hs, last_hs, sc, ov, rs);
    n_checks++;
    if (hs !== 3) begin n_fail++; $display("FAIL basic_hs: got %0d want 3", hs); end
    n_checks++;
    if (ov !== last_hs + 2) begin
      n_fail++; $display("FAIL basic_latency: out_valid at cycle %0d want %0d", ov, last_hs + 2);
    end
    n_checks++;
    if (out_data !== 32'd1200 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL basic_data: got %0d ovf=%b want 1200 ovf=0", out_data, out_ovf);
    end
    complete_out;
    n_checks++;
    if (out_valid !== 1'b0 || dbg_state !== IDLE) begin
      n_fail++; $display("FAIL basic_complete: out_valid=%b state=%0d want 0 IDLE", out_valid, dbg_state);
    end
  endtask

  task automatic test_zero;
    int hs, last_hs, sc, ov;
    bit rs;
    run_op(0, 8'd5, 8'd5, 1'b0, hs, last_hs, sc, ov, rs);
    n_checks++;
    if (ov !== sc + 1) begin n_fail++; $display("FAIL zero_latency: out_valid at %0d want %0d", ov, sc + 1); end
    n_checks++;
    if (out_data !== '0 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL zero_data: got %0d ovf=%b want 0 0", out_data, out_ovf);
    end
    n_checks++;
    if (rs !== 1'b0 || in_ready !== 1'b0 || hs !== 0) begin
      n_fail++; $display("FAIL zero_ready: ready_seen=%b in_ready=%b hs=%0d want 0 0 0", rs, in_ready, hs);
    end
    complete_out;
  endtask

  task automatic test_wrap;
    longint chunk, tot, exp;
    int hs = 0;
    bit seen = 1'b0;
    chunk = (longint'(DEPTH) * 255 * 255) % 131072;
    tot = chunk * 11;
`ifdef DP_ACC_SAT_EN
    exp = 262143;
`else
    exp = tot % 262144;
`endif
    @(negedge clk);
    w_start = 1'b1;
    w_num_chunks = CNT_W'(11);
    for (int j = 0; j < DEPTH; j++) begin
      w_in_a[j] = 8'd255;
      w_in_b[j] = 8'd255;
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      w_start = 1'b0;
      if (w_out_valid) begin
        seen = 1'b1;
        break;
      end
      w_in_valid = 1'b1;
      if (w_in_valid && w_in_ready) hs++;
    end
    w_in_valid = 1'b0;
    n_checks++;
    if (!seen || hs !== 11) begin n_fail++; $display("FAIL wrap_done: seen=%b hs=%0d want 1 11", seen, hs); end
    n_checks++;
    if (w_out_data !== W_ACC'(exp)) begin
      n_fail++; $display("FAIL wrap_data: got %0d want %0d", w_out_data, exp);
    end
    n_checks++;
    if (w_out_ovf !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf: got %b want 1", w_out_ovf); end
    @(negedge clk);
    w_out_ready = 1'b1;
    @(negedge clk);
    w_out_ready = 1'b0;
    n_checks++;
    if (w_out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_complete: out_valid=%b want 0", w_out_valid); end
  endtask

  task automatic test_hold;
    int hs, last_hs, sc, ov;
    bit rs;
    run_op(2, 8'd2, 8'd2, 1'b0, hs, last_hs, sc, ov, rs);
    n_checks++;
    if (ov < 0) begin n_fail++; $display("FAIL hold_done: out_valid never seen, want seen"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = (i == 2);
      num_chunks = CNT_W'(1);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'd32 || out_ovf !== 1'b0 || in_ready !== 1'b0 || dbg_state !== DONE) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: valid=%b data=%0d ovf=%b ready=%b state=%0d want 1 32 0 0 DONE",
                 i, out_valid, out_data, out_ovf, in_ready, dbg_state);
      end
    end
    // start coinciding with the transfer cycle must be ignored
    @(negedge clk);
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || dbg_state !== IDLE || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL hold_complete: valid=%b state=%0d ready=%b want 0 IDLE 0", out_valid, dbg_state, in_ready);
    end
  endtask

  task automatic test_reset_mid;
    int hs = 0;
    int hs2, last_hs, sc, ov;
    bit rs;
    @(negedge clk);
    start = 1'b1;
    num_chunks = CNT_W'(4);
    for (int j = 0; j < DEPTH; j++) begin
      in_a[j] = 8'd7;
      in_b[j] = 8'd7;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      if (in_valid && in_ready) hs++;
      if (hs == 2) break;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== '0 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_out: valid=%b ready=%b data=%0d ovf=%b want 0 0 0 0", out_valid, in_ready, out_data, out_ovf);
    end
    n_checks++;
    if (dp_a[0] !== 8'd0 || dp_b[0] !== 8'd0 || dbg_state !== IDLE) begin
      n_fail++; $display("FAIL rstmid_state: dp_a0=%0d dp_b0=%0d state=%0d want 0 0 IDLE", dp_a[0], dp_b[0], dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_discard: out_valid=%b want 0", out_valid); end
    run_op(1, 8'd1, 8'd1, 1'b0, hs2, last_hs, sc, ov, rs);
    n_checks++;
    if (ov < 0 || hs2 !== 1 || out_data !== 32'd4 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_resume: ov=%0d hs=%0d data=%0d ovf=%b want seen 1 4 0", ov, hs2, out_data, out_ovf);
    end
    complete_out;
  endtask

  task automatic test_gap;
    int hs, last_hs, sc, ov;
    bit rs;
    run_op(4, 8'd1, 8'd3, 1'b1, hs, last_hs, sc, ov, rs);
    n_checks++;
    if (hs !== 4) begin n_fail++; $display("FAIL gap_hs: got %0d want 4", hs); end
    n_checks++;
    if (ov !== last_hs + 2) begin n_fail++; $display("FAIL gap_latency: out_valid at %0d want %0d", ov, last_hs + 2); end
    n_checks++;
    if (out_data !== 32'd48 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL gap_data: data=%0d ovf=%b ready=%b want 48 0 0", out_data, out_ovf, in_ready);
    end
    complete_out;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset;
    test_basic;
    test_zero;
    test_wrap;
    test_hold;
    test_reset_mid;
    test_gap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
